rnd8_prbs_check: RTL and testbench
==================================

Name: rnd8_prbs_check

Overview:
- Receive-side checker for the 8-lane noise byte from the synth noise generator.
- Each bit of the byte is one independent lane carrying an x^31 + x^28 + 1 LFSR sequence. Every lane satisfies b[n] = b[n-31] XOR b[n-28].
- The block self-synchronises to each lane, flags bit errors and counts them.
- Used on the test/monitor path to qualify the noise source and any link it crosses.

Parameters:
- CNT_W, 16, width of the saturating error counter.
- LOSS_THR, 4, number of consecutive mismatches in a locked lane that forces relock (range 1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  8  received noise byte; din[i] is lane i.
- din_valid  in  1  qualifies din for this cycle; lanes advance only when high.
- clr  in  1  synchronous clear of err_count and sticky err_any; locks unaffected.
- lock  out  8  per-lane locked status.
- err_lane  out  8  per-lane one-cycle mismatch pulse (locked lanes only).
- err_any  out  1  sticky: any err_lane pulse since reset/clr.
- err_count  out  CNT_W  saturating total of mismatched bits.

Behaviour:
- Reset (async assert, sync release): all per-lane history = 0, fill counters = 0, lanes UNLOCKED. Outputs lock=0, err_lane=0, err_any=0, err_count=0.
- Per lane, a 31-bit history h: h[0] is the newest bit, h[30] the oldest.
- Expected bit e = h[30] XOR h[27], taken before the shift.
- On din_valid, h shifts left with din[i] entering h[0].
- Per-lane FSM, states UNLOCKED and LOCKED:
  - UNLOCKED: a 5-bit fill counter increments on each valid bit; no comparison is done.
  - On the valid bit that makes fill = 31, next state is LOCKED. lock[i] rises on the cycle after that bit.
  - LOCKED: every valid bit is compared with e. On mismatch, err_lane[i]=1 for exactly one cycle, registered one cycle after the sample.
  - LOCKED: a 4-bit consecutive-miss counter increments on mismatch and clears on match.
  - When the miss counter reaches LOSS_THR, the lane goes UNLOCKED, fill = 0 and miss counter = 0. lock[i] falls in the same cycle that the final err_lane[i] pulse is asserted.
  - The relocking lane refills from the bits that follow; history is not cleared.
- Received bits always update history, including mismatching bits (self-synchronising).
- din_valid low: no state change at all; err_lane = 0 next cycle.
- Latency: din -> err_lane/lock = 1 clock.
- err_count:
  - Adds the popcount of this cycle's mismatch vector (0..8) per valid cycle, registered alongside err_lane.
  - Saturates at 2^CNT_W-1 and never wraps.
  - A sum that would overflow clamps to the maximum.
- clr:
  - When clr is high with no mismatches, err_count = 0 and err_any = 0 next cycle.
  - When clr and mismatches occur in the same cycle, clr wins for that cycle: err_count = 0 and err_any = 0, and those mismatches are not counted. err_lane still pulses.
- An all-zero history is a valid fixed point of the recurrence and locks normally. Detecting it is the optional feature below.
- Reset asserted mid-operation clears everything immediately, regardless of clk.

Optional Feature:
- Macro: RND8_PRBS_CHECK_STUCK_EN.
- Defined:
  - Adds output port stuck (8 bits).
  - stuck[i]=1 while lane i is LOCKED and its history is all-zero or all-one; registered, same timing as lock.
  - A lane with stuck[i]=1 is forced UNLOCKED on the next valid bit, so lock[i] never stays high on a dead lane.
- Undefined: no stuck port or logic. An all-zero lane reports lock=1 with no errors.

Test Plan:
- Reset, then drive 40 valid bytes from 8 LFSRs seeded 31'h1A92_6572 etc. (x^31+x^28+1, tap any bit) -> lock=8'hFF from the cycle after the 31st byte; err_lane=0 throughout; err_count=0.
- After lock, invert din[3] on one valid cycle -> next cycle err_lane=8'h08, err_any=1, err_count=1. The following cycles err_lane[3] pulses exactly twice more (the inverted bit enters the n-28 and n-31 taps); lock[3] stays 1 (LOSS_THR=4); err_count=3.
- After lock, replace lane 0 with constant 1 for 10 cycles -> err_lane[0] pulses. lock[0] drops on the cycle of the 4th consecutive miss. Lane 0 relocks 31 valid cycles later only if the stream is again a valid sequence; other lanes are undisturbed.
- Hold din_valid=0 for 20 cycles mid-stream, then resume the same sequence -> no errors, lock held, counters frozen.
- CNT_W=4: inject errors on all 8 lanes in 2 consecutive cycles -> err_count=15 (saturated, not wrapping to 0). Pulse clr together with 1 further error -> err_count=0, err_any=0.
- RND8_PRBS_CHECK_STUCK_EN defined: drive din=8'h00 for 40 cycles after reset -> stuck pulses on the lock-in cycle; lock never remains high; err_count=0.

Source files
------------

// File: rtl/rnd8_prbs_check.sv
// rnd8_prbs_check: self-synchronising checker for 8 parallel x^31+x^28+1 PRBS lanes.
// Define RND8_PRBS_CHECK_STUCK_EN to add the dead-lane (all-0/all-1 history) detector.
module rnd8_prbs_check #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned LOSS_THR = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       din,
    input  logic             din_valid,
    input  logic             clr,
    output logic [7:0]       lock,
    output logic [7:0]       err_lane,
    output logic             err_any,
    output logic [CNT_W-1:0] err_count
`ifdef RND8_PRBS_CHECK_STUCK_EN
    ,
    output logic [7:0]       stuck
`endif
);

    localparam int unsigned LANES  = 8;
    localparam int unsigned HIST_W = 31;
    localparam int unsigned FILL_W = 5;
    localparam int unsigned MISS_W = 4;
    localparam int unsigned POP_W  = 4;
    localparam int unsigned SUM_W  = CNT_W + 1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lane_state_t;

    lane_state_t       state [LANES];
    logic [HIST_W-1:0] hist  [LANES];
    logic [FILL_W-1:0] fill  [LANES];
    logic [MISS_W-1:0] miss  [LANES];

    logic [LANES-1:0]  mis_c;
    logic [POP_W-1:0]  pop_c;
    logic [SUM_W-1:0]  sum_c;
    logic [CNT_W-1:0]  cnt_nxt_c;
`ifdef RND8_PRBS_CHECK_STUCK_EN
    logic [LANES-1:0]  lock_nxt_c;
    logic [LANES-1:0]  flat_nxt_c;
    logic [HIST_W-1:0] h_nxt_c;
`endif

    // Per-lane mismatch against the recurrence, and the saturating counter update
    always_comb begin
        mis_c = '0;
        pop_c = '0;
`ifdef RND8_PRBS_CHECK_STUCK_EN
        lock_nxt_c = lock;
        flat_nxt_c = '0;
        h_nxt_c    = '0;
`endif
        for (int i = 0; i < LANES; i++) begin
            if (din_valid && state[i] == LOCKED &&
                din[i] != (hist[i][HIST_W-1] ^ hist[i][HIST_W-4]))
                mis_c[i] = 1'b1;
`ifdef RND8_PRBS_CHECK_STUCK_EN
            // A stuck lane is dropped on this bit instead of being compared
            mis_c[i] = mis_c[i] & ~stuck[i];
            h_nxt_c  = {hist[i][HIST_W-2:0], din[i]};
            flat_nxt_c[i] = (h_nxt_c == '0) || (h_nxt_c == '1);
            if (din_valid) begin
                if (stuck[i])
                    lock_nxt_c[i] = 1'b0;
                else if (state[i] == UNLOCKED)
                    lock_nxt_c[i] = (fill[i] == FILL_W'(HIST_W - 1));
                else
                    lock_nxt_c[i] = !(mis_c[i] && miss[i] == MISS_W'(LOSS_THR - 1));
            end
`endif
            pop_c = pop_c + POP_W'(mis_c[i]);
        end
        sum_c     = SUM_W'(err_count) + SUM_W'(pop_c);
        cnt_nxt_c = sum_c[CNT_W] ? '1 : sum_c[CNT_W-1:0];
    end

    // Per-lane lock FSM, history shift and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                state[i] <= UNLOCKED;
                hist[i]  <= '0;
                fill[i]  <= '0;
                miss[i]  <= '0;
            end
            lock      <= '0;
            err_lane  <= '0;
            err_any   <= 1'b0;
            err_count <= '0;
`ifdef RND8_PRBS_CHECK_STUCK_EN
            stuck     <= '0;
`endif
        end else begin
            err_lane <= mis_c;
            if (clr) begin
                err_count <= '0;
                err_any   <= 1'b0;
            end else if (|mis_c) begin
                err_count <= cnt_nxt_c;
                err_any   <= 1'b1;
            end
            if (din_valid) begin
                for (int i = 0; i < LANES; i++) begin
                    hist[i] <= {hist[i][HIST_W-2:0], din[i]};
`ifdef RND8_PRBS_CHECK_STUCK_EN
                    stuck[i] <= lock_nxt_c[i] & flat_nxt_c[i];
                    if (stuck[i]) begin
                        state[i] <= UNLOCKED;
                        lock[i]  <= 1'b0;
                        fill[i]  <= '0;
                        miss[i]  <= '0;
                    end else
`endif
                    if (state[i] == UNLOCKED) begin
                        if (fill[i] == FILL_W'(HIST_W - 1)) begin
                            state[i] <= LOCKED;
                            lock[i]  <= 1'b1;
                        end
                        fill[i] <= fill[i] + FILL_W'(1);
                    end else if (mis_c[i]) begin
                        if (miss[i] == MISS_W'(LOSS_THR - 1)) begin
                            state[i] <= UNLOCKED;
                            lock[i]  <= 1'b0;
                            fill[i]  <= '0;
                            miss[i]  <= '0;
                        end else begin
                            miss[i] <= miss[i] + MISS_W'(1);
                        end
                    end else begin
                        miss[i] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rnd8_prbs_check.sv
// tb_rnd8_prbs_check: randomized bench for rnd8_prbs_check against a bit-history reference model.
// Two instances share the stimulus: default width and a 4-bit counter for saturation.
module tb_rnd8_prbs_check;

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned SAT_W    = 4;
    localparam int unsigned LOSS_THR = 4;
    localparam int unsigned MAXN     = 8192;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       din;
    logic             din_valid;
    logic             clr;
    logic [7:0]       lock, err_lane, lock_s, err_lane_s;
    logic             err_any, err_any_s;
    logic [CNT_W-1:0] err_count;
    logic [SAT_W-1:0] err_count_s;
`ifdef RND8_PRBS_CHECK_STUCK_EN
    logic [7:0]       stuck, stuck_s;
`endif

    always #5 clk = ~clk;

    rnd8_prbs_check #(.CNT_W(CNT_W), .LOSS_THR(LOSS_THR)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
        .lock(lock), .err_lane(err_lane), .err_any(err_any), .err_count(err_count)
`ifdef RND8_PRBS_CHECK_STUCK_EN
        , .stuck(stuck)
`endif
    );

    rnd8_prbs_check #(.CNT_W(SAT_W), .LOSS_THR(LOSS_THR)) dut_sat (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
        .lock(lock_s), .err_lane(err_lane_s), .err_any(err_any_s), .err_count(err_count_s)
`ifdef RND8_PRBS_CHECK_STUCK_EN
        , .stuck(stuck_s)
`endif
    );

    // Reference model: every received byte is kept, expected bit = b[n-31]^b[n-28]
    logic [7:0]  rx [0:MAXN-1];
    int          n;
    int          fill_m [8];
    int          miss_m [8];
    logic [7:0]  m_lock, m_err, m_stuck;
    logic        m_any;
    int          m_cnt, m_cnt_s;
    logic [30:0] gen [8];
    int          passed = 0;
    int          total  = 0;

    function automatic logic rx_bit(input int k, input int lane);
        if (k < 0) return 1'b0;
        return rx[k][lane];
    endfunction

    task automatic model_reset();
        n = 0;
        for (int l = 0; l < 8; l++) begin
            fill_m[l] = 0;
            miss_m[l] = 0;
        end
        m_lock = '0; m_err = '0; m_stuck = '0; m_any = 1'b0; m_cnt = 0; m_cnt_s = 0;
    endtask

    task automatic model_tick(input logic [7:0] d, input logic v, input logic c);
        logic e;
        logic same;
        int   errs;
        m_err = '0;
        if (v) begin
            for (int l = 0; l < 8; l++) begin
                e = rx_bit(n - 31, l) ^ rx_bit(n - 28, l);
                if (m_stuck[l]) begin
                    m_lock[l] = 1'b0; fill_m[l] = 0; miss_m[l] = 0;
                end else if (!m_lock[l]) begin
                    fill_m[l]++;
                    if (fill_m[l] == 31) m_lock[l] = 1'b1;
                end else if (d[l] !== e) begin
                    m_err[l] = 1'b1;
                    miss_m[l]++;
                    if (miss_m[l] == LOSS_THR) begin
                        m_lock[l] = 1'b0; fill_m[l] = 0; miss_m[l] = 0;
                    end
                end else begin
                    miss_m[l] = 0;
                end
            end
            rx[n] = d;
            n++;
`ifdef RND8_PRBS_CHECK_STUCK_EN
            for (int l = 0; l < 8; l++) begin
                same = 1'b1;
                for (int k = n - 31; k < n; k++)
                    if (rx_bit(k, l) != rx_bit(n - 1, l)) same = 1'b0;
                m_stuck[l] = m_lock[l] && same;
            end
`endif
        end
        errs = $countones(m_err);
        if (c) begin
            m_cnt = 0; m_cnt_s = 0; m_any = 1'b0;
        end else if (errs > 0) begin
            m_cnt   = (m_cnt + errs > 65535) ? 65535 : m_cnt + errs;
            m_cnt_s = (m_cnt_s + errs > 15) ? 15 : m_cnt_s + errs;
            m_any   = 1'b1;
        end
    endtask

    task automatic next_byte(output logic [7:0] b);
        logic nb;
        for (int l = 0; l < 8; l++) begin
            nb     = gen[l][30] ^ gen[l][27];
            gen[l] = {gen[l][29:0], nb};
            b[l]   = nb;
        end
    endtask

    task automatic step(input logic [7:0] d, input logic v, input logic c);
        din = d; din_valid = v; clr = c;
        @(posedge clk);
        #1;
        model_tick(d, v, c);
    endtask

    task automatic test_reset();
        rst = 1'b1; din = '0; din_valid = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({lock, err_lane, err_any, err_count, err_count_s} !== '0)
            $display("FAIL reset got %h want 0", {lock, err_lane, err_any, err_count, err_count_s});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_lock_acquire();
        logic [7:0] b;
        for (int c = 1; c <= 40; c++) begin
            next_byte(b);
            step(b, 1'b1, 1'b0);
            total++;
            if ({lock, err_lane, err_any, err_count, err_count_s} !==
                {m_lock, m_err, m_any, CNT_W'(m_cnt), SAT_W'(m_cnt_s)})
                $display("FAIL acquire c=%0d got %h want %h", c,
                    {lock, err_lane, err_any, err_count, err_count_s},
                    {m_lock, m_err, m_any, CNT_W'(m_cnt), SAT_W'(m_cnt_s)});
            else passed++;
            if (c == 30 || c == 31) begin
                total++;
                if (lock !== ((c == 31) ? 8'hFF : 8'h00))
                    $display("FAIL lock_edge c=%0d got %h", c, lock);
                else passed++;
            end
        end
    endtask

    task automatic test_single_error();
        logic [7:0] b;
        int pulses;
        next_byte(b);
        step(b ^ 8'h08, 1'b1, 1'b0);
        total++;
        if ({err_lane, err_any, err_count} !== {8'h08, 1'b1, 16'd1})
            $display("FAIL single_hit got %h want %h", {err_lane, err_any, err_count},
                     {8'h08, 1'b1, 16'd1});
        else passed++;
        pulses = 1;
        for (int c = 0; c < 40; c++) begin
            next_byte(b);
            step(b, 1'b1, 1'b0);
            if (err_lane[3]) pulses++;
            total++;
            if ({lock, err_lane, err_any, err_count, err_count_s} !==
                {m_lock, m_err, m_any, CNT_W'(m_cnt), SAT_W'(m_cnt_s)})
                $display("FAIL single_echo c=%0d got %h want %h", c,
                    {lock, err_lane, err_any, err_count, err_count_s},
                    {m_lock, m_err, m_any, CNT_W'(m_cnt), SAT_W'(m_cnt_s)});
            else passed++;
        end
        total++;
        if (pulses != 3 || {lock[3], err_count} !== {1'b1, 16'd3})
            $display("FAIL single_total pulses=%0d lock3=%b cnt=%0d want 3/1/3",
                     pulses, lock[3], err_count);
        else passed++;
    endtask

    task automatic test_lane_loss();
        logic [7:0] b;
        logic others_bad;
        others_bad = 1'b0;
        for (int c = 0; c < 160; c++) begin
            next_byte(b);
            if (c < 10) b[0] = 1'b1;
            step(b, 1'b1, 1'b0);
            if (err_lane[7:1] != 7'h00 || lock[7:1] != 7'h7F) others_bad = 1'b1;
            total++;
            if ({lock, err_lane, err_any, err_count, err_count_s} !==
                {m_lock, m_err, m_any, CNT_W'(m_cnt), SAT_W'(m_cnt_s)})
                $display("FAIL lane_loss c=%0d got %h want %h", c,
                    {lock, err_lane, err_any, err_count, err_count_s},
                    {m_lock, m_err, m_any, CNT_W'(m_cnt), SAT_W'(m_cnt_s)});
            else passed++;
        end
        total++;
        if (others_bad !== 1'b0 || lock !== 8'hFF)
            $display("FAIL lane_loss_end others_bad=%b lock=%h want 0/ff", others_bad, lock);
        else passed++;
    endtask

    task automatic test_valid_gap();
        logic [7:0]       b;
        logic [7:0]       lk;
        logic [CNT_W-1:0] snap;
        lk = lock;
        snap = err_count;
        for (int c = 0; c < 20; c++) begin
            step(8'($urandom), 1'b0, 1'b0);
            total++;
            if ({lock, err_lane, err_count} !== {lk, 8'h00, snap})
                $display("FAIL gap_hold c=%0d got %h want %h", c,
                         {lock, err_lane, err_count}, {lk, 8'h00, snap});
            else passed++;
        end
        for (int c = 0; c < 30; c++) begin
            next_byte(b);
            step(b, 1'b1, 1'b0);
            total++;
            if ({lock, err_lane, err_count} !== {lk, 8'h00, snap})
                $display("FAIL gap_resume c=%0d got %h want %h", c,
                         {lock, err_lane, err_count}, {lk, 8'h00, snap});
            else passed++;
        end
    endtask

    task automatic test_random_mix();
        logic [7:0] b;
        logic       v, c;
        int         burst, blane;
        burst = 0; blane = 0;
        for (int k = 0; k < 400; k++) begin
            v = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 49) == 0);
            if (v) begin
                next_byte(b);
                if ($urandom_range(0, 19) == 0) b ^= 8'(1 << $urandom_range(0, 7));
                if (burst == 0 && $urandom_range(0, 79) == 0) begin
                    burst = 6; blane = int'($urandom_range(0, 7));
                end
                if (burst > 0) begin
                    b[blane] = ~b[blane];
                    burst--;
                end
            end else begin
                b = 8'($urandom);
            end
            step(b, v, c);
            total++;
            if ({lock, err_lane, err_any, err_count, err_count_s} !==
                {m_lock, m_err, m_any, CNT_W'(m_cnt), SAT_W'(m_cnt_s)})
                $display("FAIL random k=%0d got %h want %h", k,
                    {lock, err_lane, err_any, err_count, err_count_s},
                    {m_lock, m_err, m_any, CNT_W'(m_cnt), SAT_W'(m_cnt_s)});
            else passed++;
        end
    endtask

    task automatic test_saturation();
        logic [7:0] b;
        for (int c = 0; c < 160; c++) begin
            next_byte(b);
            step(b, 1'b1, 1'b0);
            total++;
            if ({lock, err_lane, err_any, err_count, err_count_s} !==
                {m_lock, m_err, m_any, CNT_W'(m_cnt), SAT_W'(m_cnt_s)})
                $display("FAIL flush c=%0d got %h want %h", c,
                    {lock, err_lane, err_any, err_count, err_count_s},
                    {m_lock, m_err, m_any, CNT_W'(m_cnt), SAT_W'(m_cnt_s)});
            else passed++;
        end
        total++;
        if ({lock, lock_s} !== 16'hFFFF) $display("FAIL flush_lock got %h want ffff", {lock, lock_s});
        else passed++;
        next_byte(b);
        step(b, 1'b1, 1'b1);
        total++;
        if ({err_count, err_count_s, err_any, err_any_s} !== '0)
            $display("FAIL clr_idle got %h want 0", {err_count, err_count_s, err_any, err_any_s});
        else passed++;
        next_byte(b);
        step(~b, 1'b1, 1'b0);
        total++;
        if ({err_lane_s, err_count_s} !== {8'hFF, 4'd8})
            $display("FAIL sat_first got %h want ff8", {err_lane_s, err_count_s});
        else passed++;
        next_byte(b);
        step(~b, 1'b1, 1'b0);
        total++;
        if ({err_count, err_count_s, err_any_s} !== {16'd16, 4'd15, 1'b1})
            $display("FAIL sat_clamp got cnt=%0d cnt4=%0d any=%b want 16/15/1",
                     err_count, err_count_s, err_any_s);
        else passed++;
        next_byte(b);
        step(b ^ 8'h20, 1'b1, 1'b1);
        total++;
        if ({err_lane, err_lane_s, err_count, err_count_s, err_any, err_any_s} !==
            {8'h20, 8'h20, 16'd0, 4'd0, 1'b0, 1'b0})
            $display("FAIL clr_wins got lane=%h/%h cnt=%0d/%0d any=%b/%b want 20/20 0/0 0/0",
                     err_lane, err_lane_s, err_count, err_count_s, err_any, err_any_s);
        else passed++;
    endtask

    task automatic test_async_reset();
        logic [7:0] b;
        for (int c = 0; c < 10; c++) begin
            next_byte(b);
            step(b, 1'b1, 1'b0);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({lock, err_lane, err_any, err_count, err_count_s, lock_s} !== '0)
            $display("FAIL async_reset got %h want 0",
                     {lock, err_lane, err_any, err_count, err_count_s, lock_s});
        else passed++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 40; c++) begin
            next_byte(b);
            step(b, 1'b1, 1'b0);
            total++;
            if ({lock, err_lane, err_any, err_count, err_count_s} !==
                {m_lock, m_err, m_any, CNT_W'(m_cnt), SAT_W'(m_cnt_s)})
                $display("FAIL relock c=%0d got %h want %h", c,
                    {lock, err_lane, err_any, err_count, err_count_s},
                    {m_lock, m_err, m_any, CNT_W'(m_cnt), SAT_W'(m_cnt_s)});
            else passed++;
        end
    endtask

    task automatic test_dead_lane();
        int   run, maxrun;
        logic seen;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run = 0; maxrun = 0; seen = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            step(8'h00, 1'b1, 1'b0);
            run = lock[0] ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            total++;
            if ({lock, err_lane, err_count} !== {m_lock, m_err, CNT_W'(m_cnt)})
                $display("FAIL dead_lane c=%0d got %h want %h", c,
                         {lock, err_lane, err_count}, {m_lock, m_err, CNT_W'(m_cnt)});
            else passed++;
`ifdef RND8_PRBS_CHECK_STUCK_EN
            if (stuck != 8'h00) seen = 1'b1;
            total++;
            if ({stuck, stuck_s} !== {m_stuck, m_stuck})
                $display("FAIL stuck c=%0d got %h want %h", c, {stuck, stuck_s}, {m_stuck, m_stuck});
            else passed++;
`endif
        end
`ifdef RND8_PRBS_CHECK_STUCK_EN
        total++;
        if (!seen || maxrun > 1 || err_count !== '0)
            $display("FAIL stuck_summary seen=%b maxrun=%0d cnt=%0d want 1/<=1/0", seen, maxrun, err_count);
        else passed++;
`else
        total++;
        if (seen || maxrun != 10 || lock !== 8'hFF || err_count !== '0)
            $display("FAIL zero_lock maxrun=%0d lock=%h cnt=%0d want 10/ff/0", maxrun, lock, err_count);
        else passed++;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        gen[0] = 31'h1A92_6572;
        for (int l = 1; l < 8; l++) gen[l] = 31'($urandom) | 31'h1;
        test_reset();
        test_lock_acquire();
        test_single_error();
        test_lane_loss();
        test_valid_gap();
        test_random_mix();
        test_saturation();
        test_async_reset();
        test_dead_lane();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
